// File: rtl/execute_stage.sv
// execute_stage: pipeline EX stage with ALU, beq/bne/j resolution, redirect and wrong-path squash.
module execute_stage #(
  parameter int SQUASH_DEPTH = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DX_MemtoReg,
  input  logic             DX_RegWrite,
  input  logic             DX_MemRead,
  input  logic             DX_MemWrite,
  input  logic             DX_branch,
  input  logic             DX_jump,
  input  logic [2:0]       DX_ALUctr,
  input  logic [31:0]      DX_JT,
  input  logic [31:0]      DX_NPC,
  input  logic [31:0]      DX_A,
  input  logic [31:0]      DX_B,
  input  logic [15:0]      DX_imm,
  input  logic [4:0]       DX_RD,
  input  logic [31:0]      DX_MD,
  output logic             XM_MemtoReg,
  output logic             XM_RegWrite,
  output logic             XM_MemRead,
  output logic             XM_MemWrite,
  output logic [31:0]      XM_ALUout,
  output logic [31:0]      XM_MD,
  output logic [4:0]       XM_RD,
  output logic             XM_redirect,
  output logic [31:0]      XM_target,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] squashed_cnt
);
  logic [31:0] alu, br_target;
  logic [2:0] sq;
  logic taken, live, slt;
  assign slt = $signed(DX_A) < $signed(DX_B);
  assign br_target = DX_NPC + {{14{DX_imm[15]}}, DX_imm, 2'b00};
  assign taken = DX_jump | (DX_branch & ((DX_ALUctr == 3'd5 && DX_A == DX_B) ||
                                         (DX_ALUctr == 3'd6 && DX_A != DX_B)));
  assign live = sq == 3'd0;
  always_comb begin
    alu = DX_ALUctr == 3'd0 ? DX_A + DX_B :
          DX_ALUctr == 3'd2 ? DX_A & DX_B :
          DX_ALUctr == 3'd3 ? DX_A | DX_B :
          DX_ALUctr == 3'd4 ? {31'b0, slt} :
          DX_ALUctr == 3'd7 ? 32'd0 : DX_A - DX_B;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      XM_MemtoReg  <= 1'b0;
      XM_RegWrite  <= 1'b0;
      XM_MemRead   <= 1'b0;
      XM_MemWrite  <= 1'b0;
      XM_ALUout    <= '0;
      XM_MD        <= '0;
      XM_RD        <= '0;
      XM_redirect  <= 1'b0;
      XM_target    <= '0;
      retired_cnt  <= '0;
      squashed_cnt <= '0;
      sq           <= '0;
    end else begin
      XM_ALUout   <= alu;
      XM_MD       <= DX_MD;
      XM_RD       <= DX_RD;
      XM_MemtoReg <= DX_MemtoReg & live;
      XM_RegWrite <= DX_RegWrite & live;
      XM_MemRead  <= DX_MemRead & live;
      XM_MemWrite <= DX_MemWrite & live;
      XM_redirect <= live & taken;
      // only a live transfer may redirect or open a new squash window
      if (live && taken) begin
        XM_target <= DX_jump ? DX_JT : br_target;
        sq <= 3'(SQUASH_DEPTH);
      end else if (!live) begin
        sq <= sq - 3'd1;
      end
      if (live) retired_cnt <= retired_cnt + CNT_W'(1);
      else squashed_cnt <= squashed_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors with hand-computed expectations for execute_stage.
module tb_execute_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_branch, DX_jump;
  logic [2:0] DX_ALUctr;
  logic [31:0] DX_JT, DX_NPC, DX_A, DX_B, DX_MD;
  logic [15:0] DX_imm;
  logic [4:0] DX_RD;
  logic XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_redirect;
  logic [31:0] XM_ALUout, XM_MD, XM_target, retired_cnt, squashed_cnt;
  logic [4:0] XM_RD;
  int n_cmp = 0, n_bad = 0;

  execute_stage #(.SQUASH_DEPTH(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .DX_MemtoReg(DX_MemtoReg), .DX_RegWrite(DX_RegWrite), .DX_MemRead(DX_MemRead),
    .DX_MemWrite(DX_MemWrite), .DX_branch(DX_branch), .DX_jump(DX_jump),
    .DX_ALUctr(DX_ALUctr), .DX_JT(DX_JT), .DX_NPC(DX_NPC), .DX_A(DX_A), .DX_B(DX_B),
    .DX_imm(DX_imm), .DX_RD(DX_RD), .DX_MD(DX_MD),
    .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite), .XM_MemRead(XM_MemRead),
    .XM_MemWrite(XM_MemWrite), .XM_ALUout(XM_ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD),
    .XM_redirect(XM_redirect), .XM_target(XM_target),
    .retired_cnt(retired_cnt), .squashed_cnt(squashed_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_branch, DX_jump} = '0;
    DX_ALUctr = '0; DX_JT = '0; DX_NPC = '0; DX_A = '0; DX_B = '0;
    DX_imm = '0; DX_RD = '0; DX_MD = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] b);
    clr();
    DX_MemWrite = 1'b1; DX_A = a; DX_B = b; DX_MD = 32'hDEAD; DX_RD = 5'd9;
  endtask

  initial begin
    clr();
    #2;
    chk("rst_alu", XM_ALUout, 0);
    chk("rst_redirect", XM_redirect, 0);
    chk("rst_target", XM_target, 0);
    chk("rst_retired", retired_cnt, 0);
    chk("rst_squashed", squashed_cnt, 0);
    @(negedge clk); rst = 1'b1;
    // add
    DX_A = 1; DX_B = 2; DX_RegWrite = 1; DX_RD = 3; step();
    chk("add_alu", XM_ALUout, 3);
    chk("add_rd", XM_RD, 3);
    chk("add_regwrite", XM_RegWrite, 1);
    chk("add_redirect", XM_redirect, 0);
    chk("add_retired", retired_cnt, 1);
    // ALU sweep
    clr(); DX_A = 32'hFFFFFFFF; DX_B = 1; DX_ALUctr = 4; step();
    chk("slt_neg", XM_ALUout, 1);
    DX_A = 1; DX_B = 32'hFFFFFFFF; step();
    chk("slt_swap", XM_ALUout, 0);
    DX_A = 5; DX_B = 7; DX_ALUctr = 1; step();
    chk("sub", XM_ALUout, 32'hFFFFFFFE);
    DX_A = 32'hF0F0; DX_B = 32'hFF00; DX_ALUctr = 2; step();
    chk("and", XM_ALUout, 32'hF000);
    DX_ALUctr = 3; step();
    chk("or", XM_ALUout, 32'hFFF0);
    DX_A = 5; DX_B = 5; DX_ALUctr = 7; step();
    chk("jmp_zero", XM_ALUout, 0);
    DX_A = 32'h7FFFFFFF; DX_B = 1; DX_ALUctr = 0; step();
    chk("add_wrap", XM_ALUout, 32'h80000000);
    chk("retired_8", retired_cnt, 8);
    // beq taken, backward offset
    clr(); DX_A = 5; DX_B = 5; DX_branch = 1; DX_ALUctr = 5; DX_NPC = 32'h40; DX_imm = 16'hFFFE; step();
    chk("beq_redirect", XM_redirect, 1);
    chk("beq_target", XM_target, 32'h38);
    chk("beq_retired", retired_cnt, 9);
    sw(32'h10, 4); step();
    chk("sq1_memwrite", XM_MemWrite, 0);
    chk("sq1_redirect", XM_redirect, 0);
    chk("sq1_rd", XM_RD, 9);
    chk("sq1_md", XM_MD, 32'hDEAD);
    chk("sq1_alu", XM_ALUout, 32'h14);
    step(); step();
    chk("sq3_memwrite", XM_MemWrite, 0);
    chk("sq3_squashed", squashed_cnt, 3);
    chk("sq3_target", XM_target, 32'h38);
    step();
    chk("post_memwrite", XM_MemWrite, 1);
    chk("post_retired", retired_cnt, 10);
    // bne not taken, then j
    clr(); DX_A = 7; DX_B = 7; DX_branch = 1; DX_ALUctr = 6; step();
    chk("bne_nt_redirect", XM_redirect, 0);
    chk("bne_nt_target", XM_target, 32'h38);
    sw(1, 1); step();
    chk("bne_nt_memwrite", XM_MemWrite, 1);
    clr(); DX_jump = 1; DX_ALUctr = 7; DX_JT = 32'h100; step();
    chk("j_redirect", XM_redirect, 1);
    chk("j_target", XM_target, 32'h100);
    chk("j_retired", retired_cnt, 13);
    clr(); step();
    chk("j_pulse", XM_redirect, 0);
    step(); step();
    chk("j_squashed", squashed_cnt, 6);
    // j inside squash window
    clr(); DX_A = 1; DX_B = 1; DX_branch = 1; DX_ALUctr = 5; DX_NPC = 32'h80; DX_imm = 16'h0004; step();
    chk("beq2_target", XM_target, 32'h90);
    clr(); DX_jump = 1; DX_ALUctr = 7; DX_JT = 32'h200; step();
    chk("win_j_redirect", XM_redirect, 0);
    chk("win_j_target", XM_target, 32'h90);
    chk("win_j_squashed", squashed_cnt, 7);
    clr(); step(); step(); step();
    chk("win_end_retired", retired_cnt, 15);
    chk("win_end_squashed", squashed_cnt, 9);
    // branch with non-beq/bne ALUctr never taken; read controls pass
    clr(); DX_A = 4; DX_B = 4; DX_branch = 1; DX_MemRead = 1; DX_MemtoReg = 1; step();
    chk("br_ctr0_redirect", XM_redirect, 0);
    chk("br_ctr0_memread", XM_MemRead, 1);
    chk("br_ctr0_memtoreg", XM_MemtoReg, 1);
    // reset in the middle of a squash window
    clr(); DX_branch = 1; DX_ALUctr = 5; DX_imm = 16'h0001; step();
    chk("beq3_target", XM_target, 32'h4);
    sw(2, 2); step();
    chk("beq3_squashed", squashed_cnt, 10);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_target", XM_target, 0);
    chk("mid_rst_md", XM_MD, 0);
    chk("mid_rst_retired", retired_cnt, 0);
    chk("mid_rst_squashed", squashed_cnt, 0);
    @(negedge clk); rst = 1'b1;
    sw(3, 4); step();
    chk("after_rst_memwrite", XM_MemWrite, 1);
    chk("after_rst_alu", XM_ALUout, 7);
    chk("after_rst_retired", retired_cnt, 1);
    chk("after_rst_squashed", squashed_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
